// File: rtl/latch_bank_scheduler.sv
// latch_bank_scheduler: round-robin write scheduler for a shared bank of
// transparent D latches. One writer is granted at a time. The FSM puts the
// data on lat_d while every enable is low, then opens the addressed word's
// enable for EN_CYCLES cycles. It closes the enable again while the data is
// still stable, and finally acknowledges the writer.
//
// Handshake (req/ack): a requester raises req[i] with its req_addr/req_data
// slice valid and keeps them there until it sees ack[i]. Address and data are
// captured only at the grant edge in IDLE, so later changes are ignored.
// ack[i] is a single-cycle pulse in HOLD. A req still high after its ack is
// treated as a new request.
module latch_bank_scheduler #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int AW        = 2,
  parameter int EN_CYCLES = 2,
  parameter int GW        = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic [DW-1:0]        lat_d,
  output logic [(2**AW)-1:0]   lat_en
);

  localparam int NW = 2**AW;
  localparam int CW = $clog2(EN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state;
  logic [GW-1:0]   ptr;
  logic [AW-1:0]   addr_r;
  logic [CW-1:0]   cnt;

  logic            win_found;
  logic [GW-1:0]   win;
  logic [GW-1:0]   win_next_ptr;
  int              idx;

  // Round-robin pick: first asserted req at or after ptr, wrapping to 0.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win       = GW'(idx);
      end
    end
    win_next_ptr = (win == GW'(NREQ - 1)) ? '0 : win + GW'(1);
  end

  assign busy = (state != IDLE);

  // Write sequencer: IDLE -> SETUP -> OPEN (EN_CYCLES) -> HOLD -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      addr_r   <= '0;
      cnt      <= '0;
      grant_id <= '0;
      lat_d    <= '0;
      lat_en   <= '0;
      ack      <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_id <= win;
            addr_r   <= req_addr[int'(win)*AW +: AW];
            lat_d    <= req_data[int'(win)*DW +: DW];
            ptr      <= win_next_ptr;
            state    <= SETUP;
          end
        end
        SETUP: begin
          // Data has been stable for a full cycle; open the addressed word.
          lat_en <= NW'(1) << addr_r;
          cnt    <= '0;
          state  <= OPEN;
        end
        OPEN: begin
          if (cnt == CW'(EN_CYCLES - 1)) begin
            lat_en <= '0;
            ack    <= NREQ'(1) << grant_id;
            state  <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          lat_en <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_scheduler.sv
// Directed bench for latch_bank_scheduler with a behavioural latch bank on
// lat_en/lat_d, an ack scoreboard and per-cycle protocol checks.
module tb_latch_bank_scheduler;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int ENC  = 2;
  localparam int GW   = 2;
  localparam int NW   = 2**AW;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*AW-1:0]  req_addr = '0;
  logic [NREQ*DW-1:0]  req_data = '0;
  logic [NREQ-1:0]     ack;
  logic                busy;
  logic [GW-1:0]       grant_id;
  logic [DW-1:0]       lat_d;
  logic [NW-1:0]       lat_en;

  logic [DW-1:0]       lat_q [NW];
  logic [GW-1:0]       exp_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ack_cnt = 0;

  latch_bank_scheduler #(
    .NREQ(NREQ), .DW(DW), .AW(AW), .EN_CYCLES(ENC), .GW(GW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .req_data(req_data), .ack(ack), .busy(busy), .grant_id(grant_id),
    .lat_d(lat_d), .lat_en(lat_en)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // transparent latch bank fed by the scheduler
  always @(lat_en or lat_d) begin
    for (int i = 0; i < NW; i++)
      if (lat_en[i]) lat_q[i] = lat_d;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // per-cycle protocol checks
  logic [DW-1:0] prev_d = '0;
  logic [NW-1:0] prev_en = '0;
  logic          prev_rst_n = 1'b0;
  always @(negedge clk) begin
    check("lat_en_onehot0", 32'($onehot0(lat_en)), 32'd1);
    check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
    if (rst_n && prev_rst_n && (lat_en != '0 || prev_en != '0))
      check("lat_d_stable", 32'(lat_d), 32'(prev_d));
    if (ack != '0) ack_cnt++;
    prev_d     = lat_d;
    prev_en    = lat_en;
    prev_rst_n = rst_n;
  end

  // driver tasks
  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req[i] = 1'b1;
  endtask

  task automatic wait_ack(output int id, output int at_cyc);
    id = -1;
    at_cyc = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ack != '0) begin
        for (int i = 0; i < NREQ; i++) if (ack[i]) id = i;
        at_cyc = cyc;
        break;
      end
    end
    if (id < 0) check("ack_timeout", 32'd1, 32'd0);
    else if (exp_q.size() > 0) check("ack_id", 32'(id), 32'(exp_q.pop_front()));
    else check("ack_unexpected", 32'(id), 32'hFFFF_FFFF);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int id, c, prev_c;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lat_en", 32'(lat_en), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_lat_d", 32'(lat_d), 32'd0);
    rst_n = 1'b1;

    // 1: single write, requester 2, addr 1, data A5
    set_req(2, 2'd1, 8'hA5);
    @(negedge clk);
    check("t1_setup_busy", 32'(busy), 32'd1);
    check("t1_setup_en", 32'(lat_en), 32'd0);
    check("t1_grant", 32'(grant_id), 32'd2);
    check("t1_lat_d", 32'(lat_d), 32'hA5);
    @(negedge clk);
    check("t1_open1", 32'(lat_en), 32'b0010);
    @(negedge clk);
    check("t1_open2", 32'(lat_en), 32'b0010);
    @(negedge clk);
    check("t1_hold_en", 32'(lat_en), 32'd0);
    check("t1_hold_ack", 32'(ack), 32'b0100);
    req = '0;
    @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_ack", 32'(ack), 32'd0);
    check("t1_q1", 32'(lat_q[1]), 32'hA5);

    // 2: all four request after reset
    do_reset();
    set_req(0, 2'd3, 8'h11);
    set_req(1, 2'd2, 8'h22);
    set_req(2, 2'd1, 8'h33);
    set_req(3, 2'd0, 8'h44);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    prev_c = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(id, c);
      if (id >= 0) req[id] = 1'b0;
      if (k > 0) check("t2_ack_gap", 32'(c - prev_c), 32'd5);
      prev_c = c;
    end
    check("t2_q3", 32'(lat_q[3]), 32'h11);
    check("t2_q2", 32'(lat_q[2]), 32'h22);
    check("t2_q1", 32'(lat_q[1]), 32'h33);
    check("t2_q0", 32'(lat_q[0]), 32'h44);
    repeat (2) @(negedge clk);

    // 3: wrap-around, 3 then 0 then 3 again; same address, last writer wins
    set_req(3, 2'd2, 8'h66);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0); exp_q.push_back(2'd3);
    wait_ack(id, c);
    set_req(0, 2'd2, 8'h55);
    req_data[3*DW +: DW] = 8'h77;
    wait_ack(id, c);
    if (id >= 0) req[id] = 1'b0;
    check("t3_q2_mid", 32'(lat_q[2]), 32'h55);
    wait_ack(id, c);
    req = '0;
    check("t3_q2_last", 32'(lat_q[2]), 32'h77);
    repeat (2) @(negedge clk);

    // 4: reset during OPEN
    set_req(1, 2'd0, 8'h5A);
    @(negedge clk);
    check("t4_setup_grant", 32'(grant_id), 32'd1);
    @(negedge clk);
    check("t4_open_en", 32'(lat_en), 32'b0001);
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    check("t4_rst_en", 32'(lat_en), 32'd0);
    check("t4_rst_ack", 32'(ack), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_grant", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    set_req(1, 2'd1, 8'hC3);
    set_req(3, 2'd3, 8'h3C);
    exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    for (int k = 0; k < 2; k++) begin
      wait_ack(id, c);
      if (id >= 0) req[id] = 1'b0;
    end
    check("t4_q1", 32'(lat_q[1]), 32'hC3);
    check("t4_q3", 32'(lat_q[3]), 32'h3C);
    repeat (2) @(negedge clk);

    // 5: requester 0 drops req and changes data during SETUP
    set_req(0, 2'd1, 8'h88);
    @(negedge clk);
    check("t5_setup_busy", 32'(busy), 32'd1);
    check("t5_grant", 32'(grant_id), 32'd0);
    req = '0;
    req_data[0 +: DW] = 8'h99;
    exp_q.push_back(2'd0);
    wait_ack(id, c);
    repeat (8) @(negedge clk);
    check("t5_q1", 32'(lat_q[1]), 32'h88);
    check("t5_idle", 32'(busy), 32'd0);

    check("ack_total", 32'(ack_cnt), 32'd11);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
